// File: rtl/risc_v_mike_uart_tx_if.sv
// MMIO bus bundle shared between the core's decode path and its responders.
// The core drives address/strobe/data; a responder returns combinational read data.
interface risc_v_mike_uart_tx_if;
  logic [31:0] data_mmio_addr;
  logic        data_mmio_wr_addr_val;
  logic [31:0] data_mmio_wr_data;
  logic [31:0] data_mmio_rd_data;

  modport master (
    output data_mmio_addr,
    output data_mmio_wr_addr_val,
    output data_mmio_wr_data,
    input  data_mmio_rd_data
  );

  modport slave (
    input  data_mmio_addr,
    input  data_mmio_wr_addr_val,
    input  data_mmio_wr_data,
    output data_mmio_rd_data
  );
endinterface

// File: rtl/risc_v_mike_uart_tx.sv
// MMIO-mapped 8N1 UART transmitter with a transmit FIFO and programmable baud divisor.
// Handshake: a write is taken on every clk edge where wr_addr_val is high and the block is selected.
module risc_v_mike_uart_tx #(
  parameter logic [31:0] BASE_ADDR        = 32'h1001_0100,
  parameter int          FIFO_DEPTH       = 8,
  parameter logic [15:0] DEFAULT_BAUD_DIV = 16'd434
) (
  input  logic                        clk,
  input  logic                        rst,
  risc_v_mike_uart_tx_if.slave        mmio,
  output logic                        uart_tx,
  output logic                        tx_busy,
  output logic [1:0]                  fsm_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // ---------------- bus decode ----------------
  logic        sel;
  logic [3:0]  off;
  logic        wr_en;
  logic        push_req;
  logic        push_ok;
  logic        pop;
  logic [15:0] unused_wr_hi;

  assign sel          = (mmio.data_mmio_addr[31:4] == BASE_ADDR[31:4]);
  assign off          = mmio.data_mmio_addr[3:0];
  assign wr_en        = mmio.data_mmio_wr_addr_val & sel & (off[1:0] == 2'b00);
  assign push_req     = wr_en & (off[3:2] == 2'd0);
  assign unused_wr_hi = mmio.data_mmio_wr_data[31:16];

  // ---------------- control registers ----------------
  logic [15:0] baud_div;
  logic [15:0] baud_eff;
  logic        enable;
  logic        overflow;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  assign baud_eff = (baud_div == 16'd0) ? 16'd1 : baud_div;
  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
  assign push_ok  = push_req & (~full | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_div <= DEFAULT_BAUD_DIV;
      enable   <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (wr_en && off[3:2] == 2'd2) baud_div <= mmio.data_mmio_wr_data[15:0];
      if (wr_en && off[3:2] == 2'd3) enable   <= mmio.data_mmio_wr_data[0];
      if (push_req && full && !pop) begin
        overflow <= 1'b1;
      end else if (wr_en && off[3:2] == 2'd1 && mmio.data_mmio_wr_data[3]) begin
        overflow <= 1'b0;
      end
    end
  end

  // ---------------- transmit FIFO ----------------
  always_ff @(posedge clk) begin
    if (!rst && push_ok) fifo_mem[wr_ptr] <= mmio.data_mmio_wr_data[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- frame FSM ----------------
  state_t      state_q;
  state_t      state_d;
  logic [15:0] timer_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic        bit_done;
  logic        can_pop;

  assign bit_done = (timer_q <= 16'd1);
  assign can_pop  = enable & ~empty;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (can_pop) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_done) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_done && bit_idx_q == 3'd7) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_done) begin
          if (can_pop) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Timer reloads from the live divisor at each bit boundary, never mid-bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q   <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
    end else if (pop) begin
      shift_q   <= fifo_mem[rd_ptr];
      timer_q   <= baud_eff;
      bit_idx_q <= 3'd0;
    end else if (state_q != S_IDLE) begin
      if (bit_done) begin
        timer_q <= baud_eff;
        if (state_q == S_DATA) begin
          shift_q   <= shift_q >> 1;
          bit_idx_q <= bit_idx_q + 3'd1;
        end
      end else begin
        timer_q <= timer_q - 16'd1;
      end
    end
  end

  always_comb begin
    uart_tx = 1'b1;
    case (state_q)
      S_START: uart_tx = 1'b0;
      S_DATA:  uart_tx = shift_q[0];
      default: uart_tx = 1'b1;
    endcase
    tx_busy = (state_q != S_IDLE) | ~empty;
  end

  assign fsm_state = state_q;

  // ---------------- read mux ----------------
  // STATUS busy reports a frame on the line; queued-but-unsent bytes show via empty/count.
  logic [31:0] status_word;

  always_comb begin
    status_word          = 32'h0;
    status_word[0]       = full;
    status_word[1]       = empty;
    status_word[2]       = (state_q != S_IDLE);
    status_word[3]       = overflow;
    status_word[8 +: CW] = count;
  end

  always_comb begin
    mmio.data_mmio_rd_data = 32'h0;
    if (sel && off[1:0] == 2'b00) begin
      case (off[3:2])
        2'd1:    mmio.data_mmio_rd_data = status_word;
        2'd2:    mmio.data_mmio_rd_data = {16'h0, baud_div};
        2'd3:    mmio.data_mmio_rd_data = {31'h0, enable};
        default: mmio.data_mmio_rd_data = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_risc_v_mike_uart_tx.sv
// Bench for risc_v_mike_uart_tx: MMIO driver tasks, a line monitor checking every
// sampled clock of each frame against bytes queued in the scoreboard.
module tb_risc_v_mike_uart_tx;

  localparam logic [31:0] BASE   = 32'h1001_0100;
  localparam logic [31:0] A_TX   = BASE + 32'h0;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_BAUD = BASE + 32'h8;
  localparam logic [31:0] A_CTRL = BASE + 32'hC;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_tx;
  logic       tx_busy;
  logic [1:0] fsm_state;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  risc_v_mike_uart_tx_if bus ();

  risc_v_mike_uart_tx #(
    .BASE_ADDR(BASE), .FIFO_DEPTH(8), .DEFAULT_BAUD_DIV(16'd434)
  ) dut (
    .clk(clk), .rst(rst), .mmio(bus.slave),
    .uart_tx(uart_tx), .tx_busy(tx_busy), .fsm_state(fsm_state)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int         start_q[$];
  int         bit_len[10];
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_len(input int first4, input int rest);
    for (int i = 0; i < 10; i++) bit_len[i] = (i < 4) ? first4 : rest;
  endtask

  // ---------------- driver tasks (called on a negedge) ----------------
  task automatic mmio_wr(input logic [31:0] a, input logic [31:0] d);
    bus.data_mmio_addr        = a;
    bus.data_mmio_wr_data     = d;
    bus.data_mmio_wr_addr_val = 1'b1;
    @(negedge clk);
    bus.data_mmio_wr_addr_val = 1'b0;
    bus.data_mmio_addr        = 32'h0;
  endtask

  task automatic mmio_rd(input logic [31:0] a, output logic [31:0] d);
    bus.data_mmio_addr        = a;
    bus.data_mmio_wr_addr_val = 1'b0;
    #1;
    d = bus.data_mmio_rd_data;
    bus.data_mmio_addr = 32'h0;
  endtask

  task automatic check_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    mmio_rd(a, d);
    check_val(tag, d, exp);
  endtask

  task automatic push_byte(input logic [7:0] b);
    mmio_wr(A_TX, {24'h0, b});
    exp_q.push_back(b);
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (tx_busy !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (n >= bound) check_val("idle_timeout", 32'd1, 32'd0);
    repeat (3) @(negedge clk);
    check_val("tx_busy_idle", {31'h0, tx_busy}, 32'h0);
  endtask

  // ---------------- line monitor ----------------
  logic       mon_prev;
  logic [9:0] mon_frame;
  logic [7:0] mon_byte;
  int         mon_errs;
  bit         mon_abort;

  initial begin
    mon_prev = 1'b1;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        mon_prev = 1'b1;
      end else if (mon_prev === 1'b1 && uart_tx === 1'b0) begin
        start_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          check_val("unexpected_frame", 32'd1, 32'd0);
          mon_byte = 8'h00;
        end else begin
          mon_byte = exp_q.pop_front();
        end
        mon_frame = {1'b1, mon_byte, 1'b0};
        mon_errs  = 0;
        mon_abort = 1'b0;
        for (int i = 0; i < 10; i++) begin
          for (int j = 0; j < bit_len[i]; j++) begin
            if (!mon_abort && !(i == 0 && j == 0)) begin
              @(negedge clk); #1;
              if (rst) mon_abort = 1'b1;
            end
            if (!mon_abort && uart_tx !== mon_frame[i]) mon_errs++;
          end
        end
        check_val(mon_abort ? "frame_partial" : "frame", 32'(mon_errs), 32'd0);
        mon_prev = mon_abort ? 1'b1 : uart_tx;
      end else begin
        mon_prev = uart_tx;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b;
    bus.data_mmio_addr        = 32'h0;
    bus.data_mmio_wr_data     = 32'h0;
    bus.data_mmio_wr_addr_val = 1'b0;
    set_len(434, 434);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    #1;
    check_val("rst_uart_tx", {31'h0, uart_tx}, 32'h1);
    check_val("rst_tx_busy", {31'h0, tx_busy}, 32'h0);
    check_rd("rst_status", A_STAT, 32'h0000_0002);
    check_rd("rst_baud", A_BAUD, 32'd434);
    check_rd("rst_ctrl", A_CTRL, 32'h1);
    check_rd("txdata_reads_0", A_TX, 32'h0);
    @(negedge clk);

    // Single frame, divisor 4, latency and tx_busy timing
    set_len(4, 4);
    mmio_wr(A_BAUD, 32'd4);
    check_rd("baud_wr4", A_BAUD, 32'd4);
    push_byte(8'hA5);
    #1;
    check_val("lat_line_high_k", {31'h0, uart_tx}, 32'h1);
    check_rd("lat_count1", A_STAT, 32'h0000_0100);
    @(negedge clk); #1;
    check_val("lat_line_low_k1", {31'h0, uart_tx}, 32'h0);
    repeat (39) @(negedge clk);
    #1;
    check_val("busy_frame_end", {31'h0, tx_busy}, 32'h1);
    @(negedge clk); #1;
    check_val("busy_after_40", {31'h0, tx_busy}, 32'h0);
    check_rd("status_after_a5", A_STAT, 32'h0000_0002);
    @(negedge clk);

    // Fill with enable off, overflow, then contiguous drain
    set_len(2, 2);
    mmio_wr(A_BAUD, 32'd2);
    mmio_wr(A_CTRL, 32'd0);
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom_range(0, 255));
      mmio_wr(A_TX, {24'h0, b});
      if (i < 8) exp_q.push_back(b);
    end
    #1;
    check_val("disabled_line_idle", {31'h0, uart_tx}, 32'h1);
    check_rd("status_full_ovf", A_STAT, 32'h0000_0809);
    mmio_wr(A_STAT, 32'h8);
    check_rd("status_ovf_clr", A_STAT, 32'h0000_0801);
    start_q.delete();
    mmio_wr(A_CTRL, 32'd1);
    wait_idle(400);
    check_val("drain_frames", 32'(start_q.size()), 32'd8);
    for (int i = 0; i + 1 < start_q.size(); i++)
      check_val("frame_gap", 32'(start_q[i+1] - start_q[i]), 32'd20);
    check_val("drain_q_empty", 32'(exp_q.size()), 32'd0);

    // Push to a full FIFO in the same cycle as a pop
    mmio_wr(A_CTRL, 32'd0);
    for (int i = 0; i < 8; i++) push_byte(8'($urandom_range(0, 255)));
    start_q.delete();
    mmio_wr(A_CTRL, 32'd1);
    push_byte(8'h3E);
    check_rd("full_push_pop", A_STAT, 32'h0000_0805);
    wait_idle(500);
    check_val("full_pop_frames", 32'(start_q.size()), 32'd9);
    check_val("full_pop_q_empty", 32'(exp_q.size()), 32'd0);

    // Divisor change mid-frame, then reset mid-frame with a write ignored
    set_len(8, 3);
    mmio_wr(A_BAUD, 32'd8);
    push_byte(8'hC6);
    @(negedge clk);
    repeat (27) @(negedge clk);
    mmio_wr(A_BAUD, 32'd3);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    bus.data_mmio_addr        = A_TX;
    bus.data_mmio_wr_data     = 32'h77;
    bus.data_mmio_wr_addr_val = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.data_mmio_wr_addr_val = 1'b0;
    bus.data_mmio_addr        = 32'h0;
    exp_q.delete();
    #1;
    check_val("rst_mid_line", {31'h0, uart_tx}, 32'h1);
    check_val("rst_mid_state", {30'h0, fsm_state}, 32'h0);
    check_rd("rst_mid_status", A_STAT, 32'h0000_0002);
    check_rd("rst_mid_baud", A_BAUD, 32'd434);
    check_rd("rst_mid_ctrl", A_CTRL, 32'h1);
    @(negedge clk);

    // Unmapped / unselected accesses
    check_rd("rd_out_of_window", BASE + 32'h10, 32'h0);
    check_rd("rd_unaligned", BASE + 32'h2, 32'h0);
    check_rd("rd_unaligned_6", BASE + 32'h6, 32'h0);
    @(negedge clk);
    mmio_wr(BASE + 32'h2, 32'h55);
    mmio_wr(BASE + 32'h10, 32'h56);
    repeat (2) @(negedge clk);
    #1;
    check_rd("unaligned_wr_nop", A_STAT, 32'h0000_0002);
    check_val("unaligned_wr_line", {31'h0, uart_tx}, 32'h1);
    @(negedge clk);

    // Divisor 0 behaves as 1
    set_len(1, 1);
    mmio_wr(A_BAUD, 32'd0);
    check_rd("baud_zero_rd", A_BAUD, 32'd0);
    start_q.delete();
    push_byte(8'h5A);
    push_byte(8'h81);
    wait_idle(100);
    check_val("baud0_frames", 32'(start_q.size()), 32'd2);
    if (start_q.size() == 2)
      check_val("baud0_gap", 32'(start_q[1] - start_q[0]), 32'd10);
    check_val("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
